mips_mc_control: RTL

- Multi-cycle sequencer for the MIPS datapath: a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback.
- Lets the datapath share one ALU and one unified instruction/data memory port.
- Replaces the single-cycle Control_Unit when the core is rebuilt as the multi-cycle variant.
- Drives all datapath enables and mux selects, and waits on a memory-ready handshake.

---
 rtl/mips_pkg.sv | 127 ++++++++++++
 rtl/mips_mc_aludec.sv | 25 ++
 rtl/mips_mc_control.sv | 102 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: state encoding,
// instruction field constants, datapath select codes and the per-state decode.
package mips_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11,
    S_FAULT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU_RES = 2'b00;
  localparam logic [1:0] PC_ALU_OUT = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;

  // fetch/branch/jump are PC-write qualifiers; the live gating happens in the top.
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctl;
    logic [1:0] pc_src;
    logic       fetch;
    logic       branch;
    logic       jump;
    logic       fault;
  } ctl_t;

  function automatic ctl_t decode_ctl(state_t s, logic [2:0] rtype_alu);
    ctl_t c;
    c         = '0;
    c.alu_ctl = ALU_ADD;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.pc_src    = PC_ALU_RES;
        c.fetch     = 1'b1;
      end
      S_DECODE:   c.alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEMWB: begin
        c.memto_reg = 1'b1;
        c.reg_write = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_RTYPE_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_ctl   = rtype_alu;
      end
      S_RTYPE_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_ctl   = ALU_SUB;
        c.pc_src    = PC_ALU_OUT;
        c.branch    = 1'b1;
      end
      S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB:  c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_src = PC_JUMP;
        c.jump   = 1'b1;
      end
      default:    c.fault = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_mc_aludec.sv
// Funct-field decoder for R-type instructions: yields the ALU operation and
// flags any Funct the core does not implement.
module mips_mc_aludec
  import mips_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctl,
  output logic       o_illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    o_alu_ctl = ALU_ADD;
    o_illegal = 1'b0;
    case (i_funct)
      FN_ADD:  o_alu_ctl = ALU_ADD;
      FN_SUB:  o_alu_ctl = ALU_SUB;
      FN_AND:  o_alu_ctl = ALU_AND;
      FN_OR:   o_alu_ctl = ALU_OR;
      FN_SLT:  o_alu_ctl = ALU_SLT;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Moore sequencer for the multi-cycle MIPS datapath. Control outputs are
// registered alongside the state; only the PC/IR write strobes see live inputs.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               zero,
  input  logic               MemReady,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALU_Control,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic               Fault,
  output logic [STATE_W-1:0] dbg_state
);

  state_t     r_state;
  state_t     w_next;
  ctl_t       r_ctl;
  logic [2:0] w_rtype_alu;
  logic       w_funct_illegal;
  logic       w_fetch_go;

  mips_mc_aludec u_aludec (
    .i_funct   (Funct),
    .o_alu_ctl (w_rtype_alu),
    .o_illegal (w_funct_illegal)
  );

  always_comb begin
    w_next = S_FAULT;
    case (r_state)
      S_FETCH:  w_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPE_EX;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDI_EX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FAULT;
        endcase
      end
      S_MEMADR:   w_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_next = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWR:    w_next = MemReady ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: w_next = w_funct_illegal ? S_FAULT : S_RTYPE_WB;
      S_RTYPE_WB: w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_ADDI_EX:  w_next = S_ADDI_WB;
      S_ADDI_WB:  w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      default:    w_next = S_FAULT;
    endcase
  end

  // The control word is decoded from the state being entered, so it is
  // already valid in the first cycle of that state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state <= S_FETCH;
      r_ctl   <= decode_ctl(S_FETCH, ALU_ADD);
    end else begin
      r_state <= w_next;
      r_ctl   <= decode_ctl(w_next, w_rtype_alu);
    end
  end

  // Reset masks the FETCH strobes so an asserted MemReady cannot write PC/IR.
  assign w_fetch_go  = r_ctl.fetch & MemReady & ~rst;

  assign IorD        = r_ctl.iord;
  assign MemRead     = r_ctl.mem_read;
  assign MemWrite    = r_ctl.mem_write;
  assign IRWrite     = w_fetch_go;
  assign RegDst      = r_ctl.reg_dst;
  assign MemtoReg    = r_ctl.memto_reg;
  assign RegWrite    = r_ctl.reg_write;
  assign ALUSrcA     = r_ctl.alu_src_a;
  assign ALUSrcB     = r_ctl.alu_src_b;
  assign ALU_Control = r_ctl.alu_ctl;
  assign PCSrc       = r_ctl.pc_src;
  assign PCEn        = w_fetch_go | (r_ctl.branch & zero) | r_ctl.jump;
  assign Fault       = r_ctl.fault;
  assign dbg_state   = STATE_W'(r_state);

endmodule
